// File: rtl/clkdiv_if.sv
// ----------------------------------------------------------------------------
// clkdiv_if
// Control and status bundle of the programmable clock divider.
//
// Signals:
//   en          run request, sampled by the divider only at period boundaries
//   div         requested divisor
//   div_load    single-cycle strobe, captures div as the pending divisor
//   clk_out     divided clock
//   tick        one source-cycle pulse per output period, with the clk_out rise
//   busy        an output period is in progress
//   div_active  divisor in force for the current/next period
//
// Handshake: div_load is a plain strobe with no back-pressure. Every clk_in
// posedge that sees div_load=1 captures div; the divider never refuses a load
// and the last load before a period boundary is the one that takes effect.
//
// Modports: master = controller side, slave = divider side.
// ----------------------------------------------------------------------------
interface clkdiv_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [WIDTH-1:0] div_active;

    modport master (
        output en,
        output div,
        output div_load,
        input  clk_out,
        input  tick,
        input  busy,
        input  div_active
    );

    modport slave (
        input  en,
        input  div,
        input  div_load,
        output clk_out,
        output tick,
        output busy,
        output div_active
    );
endinterface

// File: rtl/clkdiv_prog.sv
// ----------------------------------------------------------------------------
// clkdiv_prog
// Runtime-programmable integer clock divider: clk_out = clk_in / D with 50 %
// duty for both even and odd D. Odd D uses a negedge half-cycle register to
// stretch the high phase by half a source cycle.
//
// Ports:
//   clk_in   source clock (posedge logic, plus one negedge register)
//   rst_n    asynchronous active-low reset
//   bus      clkdiv_if slave modport (en, div, div_load in;
//            clk_out, tick, busy, div_active out)
//
// Parameters:
//   WIDTH        width of the divisor and of the period counter
//   DEFAULT_DIV  divisor in force after reset (2 .. 2^WIDTH-1)
// ----------------------------------------------------------------------------
module clkdiv_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 25
) (
    input  logic     clk_in,
    input  logic     rst_n,
    clkdiv_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_pending;
    logic             r_pending_valid;
    logic [WIDTH-1:0] r_div_active;
    logic             r_busy;
    logic             r_phase;
    logic             r_odd;
    logic             r_tick;
    logic             r_half;

    logic             w_last;
    logic             w_boundary;
    logic             w_start;
    logic [WIDTH-1:0] w_next_div;
    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_half_len;
    logic [WIDTH-1:0] w_load_val;

    // div_active is always >= 2, so D-1 never underflows and the counter
    // never needs to exceed D-1 (no wrap even for D = 2^WIDTH-1).
    assign w_last     = (r_cnt == (r_div_active - ONE));
    // A boundary is either idle or the last cycle of a running period.
    assign w_boundary = !r_busy || w_last;
    assign w_start    = w_boundary && bus.en;
    assign w_next_div = r_pending_valid ? r_pending : r_div_active;
    assign w_cnt_inc  = r_cnt + ONE;
    assign w_half_len = r_div_active >> 1;
    // Divisors 0 and 1 cannot produce a waveform; treat them as 2.
    assign w_load_val = (bus.div <= ONE) ? TWO : bus.div;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_div_active    <= WIDTH'(DEFAULT_DIV);
            r_busy          <= 1'b0;
            r_phase         <= 1'b0;
            r_odd           <= 1'b0;
            r_tick          <= 1'b0;
        end else begin
            if (bus.div_load) begin
                r_pending <= w_load_val;
            end

            // A load on the start edge itself stays pending for the next
            // boundary, so it must win over the clear.
            if (bus.div_load) begin
                r_pending_valid <= 1'b1;
            end else if (w_start) begin
                r_pending_valid <= 1'b0;
            end

            if (w_start) begin
                r_div_active <= w_next_div;
                r_odd        <= w_next_div[0];
                r_cnt        <= '0;
                r_busy       <= 1'b1;
                r_phase      <= 1'b1;   // H = floor(D/2) >= 1 always
                r_tick       <= 1'b1;
            end else if (w_boundary) begin
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_phase <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_inc;
                // High for counts 0 .. H-1.
                r_phase <= (w_cnt_inc < w_half_len);
                r_tick  <= 1'b0;
            end
        end
    end

    // Half-cycle register: follows phase half a cycle late for odd D, so the
    // OR below is high H+0.5 cycles. Only one of phase/half moves per edge.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_half <= 1'b0;
        end else begin
            r_half <= r_odd & r_phase;
        end
    end

    assign bus.clk_out    = r_phase | r_half;
    assign bus.tick       = r_tick;
    assign bus.busy       = r_busy;
    assign bus.div_active = r_div_active;

endmodule

// File: tb/tb_clkdiv_prog.sv
// ----------------------------------------------------------------------------
// tb_clkdiv_prog
// Self-checking bench for clkdiv_prog (WIDTH=8, DEFAULT_DIV=25).
// A reference model tracks period position and divisor; clk_out is expected
// high for the first D half-cycles of each 2D half-cycle period.
// ----------------------------------------------------------------------------
module tb_clkdiv_prog;
    logic clk;
    logic rst_n;

    clkdiv_if #(.WIDTH(8)) bus ();

    clkdiv_prog #(.WIDTH(8), .DEFAULT_DIV(25)) dut (
        .clk_in (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy;
    int m_pos;
    int m_d;
    int m_pend;
    bit m_pv;
    bit m_tick;

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_d = 25; m_pend = 0; m_pv = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit e, input int d, input bit ld);
        bit boundary;
        boundary = !m_busy || (m_pos == m_d - 1);
        if (boundary) begin
            if (e) begin
                if (m_pv) begin
                    m_d  = m_pend;
                    m_pv = 0;
                end
                m_pos = 0; m_busy = 1; m_tick = 1;
            end else begin
                m_pos = 0; m_busy = 0; m_tick = 0;
            end
        end else begin
            m_pos++;
            m_tick = 0;
        end
        if (ld) begin
            m_pend = (d < 2) ? 2 : d;
            m_pv   = 1;
        end
    endtask

    function automatic bit model_clk(input int half_idx);
        return m_busy && (half_idx < m_d);
    endfunction

    // Values captured in the last step, for the table comparisons.
    logic       s_co_hi, s_co_lo, s_tick, s_busy;
    logic [7:0] s_da;

    // ---------------- driver ----------------
    task automatic step(input logic e, input logic [7:0] d, input logic ld);
        bus.en = e; bus.div = d; bus.div_load = ld;
        @(posedge clk);
        model_edge(e, int'(d), ld);
        #1;
        s_co_hi = bus.clk_out; s_tick = bus.tick; s_busy = bus.busy; s_da = bus.div_active;
        check("clk_out_first_half", 32'(bus.clk_out), 32'(model_clk(2 * m_pos)));
        check("tick", 32'(bus.tick), 32'(m_tick));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("div_active", 32'(bus.div_active), 32'(m_d));
        @(negedge clk);
        #1;
        s_co_lo = bus.clk_out;
        check("clk_out_second_half", 32'(bus.clk_out), 32'(model_clk(2 * m_pos + 1)));
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.div = '0; bus.div_load = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_clk_out", 32'(bus.clk_out), 32'd0);
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_div_active", 32'(bus.div_active), 32'd25);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic [7:0] div;
        logic       ld;
        logic       co_hi;
        logic       co_lo;
        logic       tick;
        logic       busy;
        logic [7:0] da;
    } vec_t;

    vec_t tbl[20];

    initial begin
        bit         e, ld;
        logic [7:0] d;
        int         sel;

        rst_n = 1'b1;
        bus.en = 1'b0; bus.div = '0; bus.div_load = 1'b0;
        model_reset();
        #2;

        //            en    div    ld   hi lo tk bz  da
        tbl[0]  = '{1'b0, 8'd3, 1'b1, 0, 0, 0, 0, 8'd25}; // idle load 3
        tbl[1]  = '{1'b1, 8'd0, 1'b0, 1, 1, 1, 1, 8'd3 }; // P0, D=3
        tbl[2]  = '{1'b1, 8'd0, 1'b0, 1, 0, 0, 1, 8'd3 }; // falls mid-cycle
        tbl[3]  = '{1'b1, 8'd0, 1'b0, 0, 0, 0, 1, 8'd3 };
        tbl[4]  = '{1'b1, 8'd0, 1'b1, 1, 1, 1, 1, 8'd3 }; // load on P0 not applied
        tbl[5]  = '{1'b0, 8'd0, 1'b0, 1, 0, 0, 1, 8'd3 }; // en ignored mid-period
        tbl[6]  = '{1'b0, 8'd0, 1'b0, 0, 0, 0, 1, 8'd3 };
        tbl[7]  = '{1'b0, 8'd0, 1'b0, 0, 0, 0, 0, 8'd3 }; // idle
        tbl[8]  = '{1'b1, 8'd0, 1'b0, 1, 1, 1, 1, 8'd2 }; // div=0 clamped to 2
        tbl[9]  = '{1'b1, 8'd0, 1'b0, 0, 0, 0, 1, 8'd2 };
        tbl[10] = '{1'b1, 8'd1, 1'b1, 1, 1, 1, 1, 8'd2 }; // load 1 pending
        tbl[11] = '{1'b0, 8'd0, 1'b0, 0, 0, 0, 1, 8'd2 };
        tbl[12] = '{1'b0, 8'd0, 1'b0, 0, 0, 0, 0, 8'd2 };
        tbl[13] = '{1'b1, 8'd4, 1'b1, 1, 1, 1, 1, 8'd2 }; // div=1 clamped to 2
        tbl[14] = '{1'b1, 8'd0, 1'b0, 0, 0, 0, 1, 8'd2 };
        tbl[15] = '{1'b1, 8'd0, 1'b0, 1, 1, 1, 1, 8'd4 }; // D=4
        tbl[16] = '{1'b1, 8'd0, 1'b0, 1, 1, 0, 1, 8'd4 };
        tbl[17] = '{1'b1, 8'd0, 1'b0, 0, 0, 0, 1, 8'd4 };
        tbl[18] = '{1'b0, 8'd0, 1'b0, 0, 0, 0, 1, 8'd4 };
        tbl[19] = '{1'b0, 8'd0, 1'b0, 0, 0, 0, 0, 8'd4 }; // idle

        // ---- table-driven vectors ----
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].en, tbl[i].div, tbl[i].ld);
            check($sformatf("tbl%0d_co_hi", i), 32'(s_co_hi), 32'(tbl[i].co_hi));
            check($sformatf("tbl%0d_co_lo", i), 32'(s_co_lo), 32'(tbl[i].co_lo));
            check($sformatf("tbl%0d_tick", i), 32'(s_tick), 32'(tbl[i].tick));
            check($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_da", i), 32'(s_da), 32'(tbl[i].da));
        end

        // ---- defaults, then mid-period load of 4 at cycle 7 ----
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i == 7) ? 8'd4 : 8'd0, i == 7);
            if (i == 12) check("d25_high_last_full", 32'(s_co_lo), 32'd0);
            if (i == 24) check("d25_da_before_boundary", 32'(s_da), 32'd25);
            if (i == 25) check("d4_da_at_boundary", 32'(s_da), 32'd4);
            if (i == 25) check("d4_tick_at_boundary", 32'(s_tick), 32'd1);
        end

        // ---- en dropped at cycle 5, raised later ----
        do_reset();
        for (int i = 0; i < 40; i++) step(i < 5, 8'd0, 1'b0);
        check("en_low_idle_busy", 32'(s_busy), 32'd0);
        step(1'b1, 8'd0, 1'b0);
        check("en_return_rise", 32'(s_co_hi), 32'd1);
        for (int i = 0; i < 30; i++) step(1'b1, 8'd0, 1'b0);

        // ---- async reset while clk_out high at cycle 3 ----
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'd0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", 32'(bus.clk_out), 32'd0);
        check("async_rst_tick", 32'(bus.tick), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_div_active", 32'(bus.div_active), 32'd25);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 55; i++) step(1'b1, 8'd0, 1'b0);

        // ---- div=255 extreme ----
        do_reset();
        step(1'b0, 8'd255, 1'b1);
        for (int i = 0; i < 520; i++) step(1'b1, 8'd0, 1'b0);

        // ---- back-to-back loads of 10 then 6 within one period ----
        do_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'b1, (i == 3) ? 8'd10 : 8'd6, (i == 3) || (i == 4));
        end
        check("b2b_last_wins", 32'(s_da), 32'd6);

        // ---- randomized stimulus against the model ----
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            e   = ($urandom_range(0, 9) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)      d = 8'($urandom_range(0, 12));
            else if (sel < 9) d = 8'($urandom_range(13, 40));
            else              d = 8'($urandom_range(200, 255));
            step(e, d, ld);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clkdiv_prog.md
# clkdiv_prog

Runtime-programmable integer clock divider: generalised successor to the fixed divide-by-25 divider. It produces an output clock at clk_in / D with 50 % duty for both even and odd D; odd D uses a negative-edge half-cycle register. D can be changed glitch-free at period boundaries, and the output can be gated on and off cleanly. It sits between the master oscillator and the S/PDIF/I2S clocking logic, providing MCLK/BCLK-class clocks without per-ratio RTL.

## Interface
- WIDTH, 8, width of divisor input and of the internal counter
- DEFAULT_DIV, 25, divisor after reset; must satisfy 2 ≤ DEFAULT_DIV ≤ 2^WIDTH−1
- clk_in  input  1  source clock; all logic on posedge except the half-cycle register (negedge)
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  run request; sampled only at period boundaries
- div  input  WIDTH  requested divisor
- div_load  input  1  single-cycle strobe: capture div as pending divisor
- clk_out  output  1  divided clock
- tick  output  1  one clk_in-cycle pulse per output period, aligned to the clk_out rising edge
- busy  output  1  output period in progress
- div_active  output  WIDTH  divisor in force for the current/next period

## Operation
- Reset, asynchronous, takes effect immediately:
  - clk_out=0, tick=0, busy=0, half register=0.
  - div_active=DEFAULT_DIV; pending cleared; counter=0; idle.
- Divisor capture:
  - A posedge with div_load=1 stores div into pending and sets pending_valid.
  - Values 0 and 1 are clamped to 2.
  - Several loads before a boundary: last one wins.
- Period start (P0): a posedge where the unit is idle, or the previous period has completed, and en=1.
  - If pending_valid: div_active←pending and pending_valid cleared, at that same edge. The new D governs this period.
  - A div_load sampled on the P0 edge itself is not applied to this period; it waits for the next boundary.
- Waveform with D=div_active, H=floor(D/2):
  - phase register high for H clk_in cycles from P0, low for D−H cycles.
  - Odd D: half register ← phase on negedge. clk_out = phase | half. Result: high H+0.5 cycles, low H+0.5 cycles.
  - Even D: half forced 0; clk_out = phase. Result: high H, low H.
  - The odd/even select is latched at P0 together with D.
  - Only one of phase/half changes per clock edge, so clk_out is glitch-free.
- Enable gating:
  - en is ignored mid-period; the current period always completes.
  - If en=0 at the boundary edge: no new P0. clk_out stays 0, busy←0, counter holds 0.
  - When en returns to 1: P0 occurs on the first posedge that samples en=1.
- Counter:
  - Counts 0..D−1 and wraps at D−1 to a new P0 (or to idle).
  - Compares are WIDTH-bit unsigned; no overflow for D up to 2^WIDTH−1.

## Timing
- clk_out rises exactly at P0. Subsequent rises at P0+D, P0+2D, … while en=1.
- tick is registered: high during the clk_in cycle following each P0 edge, i.e. the same cycle clk_out goes high.
- busy=1 from P0 through the last cycle of a period; it falls at the boundary only if no new P0 follows.
- div_active updates at P0. Latency from div_load to effect: ≥1 edge, ≤ current D + 1 cycles while running.
- From idle with en=1 and div_load on edge k: the pending value applies at P0 = edge k+1.
- Reset may be asserted at any point, including clk_out high mid-period. Outputs drop at once, with no wait for a clock.
- After rst_n deasserts, the first P0 is on the first posedge that samples en=1.

## Test plan
- Reset defaults, en=1 held: clk_out period 25 clk_in cycles, high 12.5 / low 12.5. tick once per period, coincident with the rise. div_active=25.
- Mid-period load of div=4 at cycle 7 of a 25-cycle period: that period still ends at 25. The next periods are 4 cycles, 2 high / 2 low. div_active changes 25→4 exactly at the boundary edge.
- Small divisors, loaded from idle then en=1:
  - div=2 → 1/1
  - div=3 → 1.5/1.5
  - div=0 and div=1 → 1/1, with div_active=2
- en dropped at cycle 5 of a 25-cycle period: the period completes at 25, then clk_out=0 and busy=0 with no runt pulse. en raised again: clk_out rises on the first edge that samples en=1.
- Reset while clk_out is high at cycle 3: clk_out, tick and busy go to 0 asynchronously and div_active=25. After release with en=1: a normal 25-cycle waveform.
- Extremes with WIDTH=8, div=255: high 127.5 / low 127.5, no counter wrap error. Back-to-back loads of 10 then 6 within one period: only 6 is applied.
